// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: EX_MEM / MEM_WB bundle layouts,
// MemToReg encodings and MEM-stage FSM states.
package mem_stage_pkg;

    localparam int EX_MEM_W = 139;
    localparam int MEM_WB_W = 38;

    typedef enum logic [1:0] {
        MTR_ALU     = 2'b00,
        MTR_MEM     = 2'b01,
        MTR_PC4     = 2'b10,
        MTR_ALU_ALT = 2'b11
    } mtr_t;

    // Packed layout, MSB first; lsb offsets:
    // store 0, alu 32, wreg 64, mrd 69, mwr 70,
    // rwr 71, mtr 72, pc4 74, lud 106, luop 138
    typedef struct packed {
        logic        lu_op;
        logic [31:0] lu_data;
        logic [31:0] pc_plus4;
        mtr_t        mem_to_reg;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } ex_mem_t;

    // lsb offsets: data 0, wreg 32, rwr 37
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  write_reg;
        logic [31:0] data;
    } mem_wb_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_stage_wb_mux.sv
// Register write-data select shared by forwarding and MEM_WB.
// Ports: lu_op/lu_data, mem_to_reg, alu/mem/pc4 sources -> data.
module wb_mux
    import mem_stage_pkg::*;
(
    input  logic        lu_op,
    input  logic [31:0] lu_data,
    input  mtr_t        mem_to_reg,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic [31:0] pc_plus4,
    output logic [31:0] data
);

    always_comb begin
        data = alu_result;
        if (lu_op) begin
            data = lu_data;
        end else begin
            unique case (mem_to_reg)
                MTR_MEM: data = mem_data;
                MTR_PC4: data = pc_plus4;
                default: data = alu_result;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake FSM with timeout,
// misalignment trap, forwarding taps and MEM_WB register.
// Ports: clk/reset_b, EX_MEM in, dmem_* bus, MemStall,
// EX_MEM_* forwarding taps, MEM_WB out, sticky bus_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic [EX_MEM_W-1:0] EX_MEM,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    output logic                MemStall,
    output logic [4:0]          EX_MEM_Rd,
    output logic [31:0]         EX_MEM_RdData,
    output logic                EX_MEM_RegWrite,
    output logic [MEM_WB_W-1:0] MEM_WB,
    output logic                bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    ex_mem_t     ex;
    state_t      state;
    state_t      state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0] rdata_q;
    logic [31:0] wb_data;
    logic        mem_op;
    logic        aligned;
    logic        expired;

    assign ex      = ex_mem_t'(EX_MEM);
    assign mem_op  = ex.mem_read | ex.mem_write;
    assign aligned = (ex.alu_result[1:0] == 2'b00);
    assign expired = (cnt == CW'(TIMEOUT - 1));

    assign EX_MEM_Rd       = ex.write_reg;
    assign EX_MEM_RegWrite = ex.reg_write;

    // Forwarding never sees loaded data, so the
    // memory leg falls back to the ALU result.
    wb_mux u_fwd_mux (
        .lu_op      (ex.lu_op),
        .lu_data    (ex.lu_data),
        .mem_to_reg (ex.mem_to_reg),
        .alu_result (ex.alu_result),
        .mem_data   (ex.alu_result),
        .pc_plus4   (ex.pc_plus4),
        .data       (EX_MEM_RdData)
    );

    wb_mux u_wb_mux (
        .lu_op      (ex.lu_op),
        .lu_data    (ex.lu_data),
        .mem_to_reg (ex.mem_to_reg),
        .alu_result (ex.alu_result),
        .mem_data   (rdata_q),
        .pc_plus4   (ex.pc_plus4),
        .data       (wb_data)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    state_nxt = aligned ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (dmem_ack || expired) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        MemStall = 1'b0;
        dmem_req = 1'b0;
        unique case (state)
            ST_IDLE: MemStall = mem_op;
            ST_REQ: begin
                MemStall = 1'b1;
                dmem_req = 1'b1;
            end
            default: begin
                MemStall = 1'b0;
                dmem_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt        <= '0;
            rdata_q    <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            bus_err    <= 1'b0;
            MEM_WB     <= '0;
        end else begin
            // Only IDLE leads into REQ, so clearing here
            // gives a fresh count on every entry.
            if (state == ST_IDLE) begin
                cnt <= '0;
            end else if (state == ST_REQ) begin
                cnt <= cnt + 1'b1;
            end

            if (state == ST_IDLE && mem_op) begin
                if (aligned) begin
                    dmem_addr  <= ex.alu_result;
                    dmem_wdata <= ex.store_data;
                    dmem_we    <= ex.mem_write;
                end else begin
                    bus_err <= 1'b1;
                    rdata_q <= '0;
                end
            end

            if (state == ST_REQ) begin
                if (dmem_ack) begin
                    rdata_q <= dmem_rdata;
                    dmem_we <= 1'b0;
                end else if (expired) begin
                    bus_err <= 1'b1;
                    rdata_q <= '0;
                    dmem_we <= 1'b0;
                end
            end

            if (MemStall) begin
                MEM_WB <= '0;
            end else begin
                MEM_WB <= {ex.reg_write, ex.write_reg, wb_data};
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle ops
// plus directed load/store/misaligned/reset/timeout sequences.
module tb_mem_stage;

    logic         clk;
    logic         reset_b;
    logic [138:0] EX_MEM;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         MemStall;
    logic [4:0]   EX_MEM_Rd;
    logic [31:0]  EX_MEM_RdData;
    logic         EX_MEM_RegWrite;
    logic [37:0]  MEM_WB;
    logic         bus_err;

    int n_chk = 0;
    int n_fail = 0;

    mem_stage dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .EX_MEM          (EX_MEM),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .MemStall        (MemStall),
        .EX_MEM_Rd       (EX_MEM_Rd),
        .EX_MEM_RdData   (EX_MEM_RdData),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .MEM_WB          (MEM_WB),
        .bus_err         (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [138:0] ex;
        logic [37:0]  wb;
        logic [31:0]  fwd;
        logic [4:0]   rd;
        logic         rw;
    } vec_t;

    vec_t vt[6];

    function automatic logic [138:0] mk(
        input logic [31:0] alu,
        input logic [31:0] sd,
        input logic [4:0]  wr,
        input logic        mr,
        input logic        mw,
        input logic        rw,
        input logic [1:0]  mtr,
        input logic [31:0] pc4,
        input logic [31:0] lud,
        input logic        luop
    );
        return {luop, lud, pc4, mtr, rw, mw, mr, wr, alu, sd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    int n;

    initial begin
        vt[0] = '{mk(32'h5, 0, 5'd8, 0, 0, 1, 2'b00, 32'h0, 32'h0, 0),
                  {1'b1, 5'd8, 32'h5}, 32'h5, 5'd8, 1'b1};
        vt[1] = '{mk(32'hDEADBEEF, 0, 5'd31, 0, 0, 1, 2'b11, 32'h8, 32'h0, 0),
                  {1'b1, 5'd31, 32'hDEADBEEF}, 32'hDEADBEEF, 5'd31, 1'b1};
        vt[2] = '{mk(32'h44, 0, 5'd1, 0, 0, 1, 2'b10, 32'h1004, 32'h0, 0),
                  {1'b1, 5'd1, 32'h1004}, 32'h1004, 5'd1, 1'b1};
        vt[3] = '{mk(32'h7, 0, 5'd3, 0, 0, 1, 2'b00, 32'h0, 32'hABCD0000, 1),
                  {1'b1, 5'd3, 32'hABCD0000}, 32'hABCD0000, 5'd3, 1'b1};
        vt[4] = '{mk(32'h9, 0, 5'd7, 0, 0, 0, 2'b00, 32'h0, 32'h0, 0),
                  {1'b0, 5'd7, 32'h9}, 32'h9, 5'd7, 1'b0};
        vt[5] = '{mk(32'h1, 0, 5'd2, 0, 0, 1, 2'b10, 32'h2000, 32'h12340000, 1),
                  {1'b1, 5'd2, 32'h12340000}, 32'h12340000, 5'd2, 1'b1};

        reset_b = 1'b0;
        EX_MEM = '0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        #12;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_memwb", MEM_WB, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_stall", MemStall, 0);
        @(negedge clk);
        reset_b = 1'b1;
        tick();
        chk("post_rst_stall", MemStall, 0);

        for (int i = 0; i < 6; i++) begin
            EX_MEM = vt[i].ex;
            #1;
            chk($sformatf("v%0d_stall", i), MemStall, 0);
            chk($sformatf("v%0d_fwd", i), EX_MEM_RdData, vt[i].fwd);
            chk($sformatf("v%0d_rd", i), EX_MEM_Rd, vt[i].rd);
            chk($sformatf("v%0d_rw", i), EX_MEM_RegWrite, vt[i].rw);
            tick();
            chk($sformatf("v%0d_memwb", i), MEM_WB, vt[i].wb);
        end

        // Load with ack on the second REQ cycle.
        EX_MEM = mk(32'h100, 0, 5'd5, 1, 0, 1, 2'b01, 0, 0, 0);
        #1;
        chk("ld_idle_stall", MemStall, 1);
        chk("ld_idle_req", dmem_req, 0);
        tick();
        chk("ld_r1_req", dmem_req, 1);
        chk("ld_r1_stall", MemStall, 1);
        chk("ld_r1_addr", dmem_addr, 32'h100);
        chk("ld_r1_we", dmem_we, 0);
        chk("ld_r1_bubble", MEM_WB[37], 0);
        tick();
        chk("ld_r2_req", dmem_req, 1);
        chk("ld_r2_stall", MemStall, 1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        chk("ld_done_req", dmem_req, 0);
        chk("ld_done_stall", MemStall, 0);
        tick();
        EX_MEM = '0;
        chk("ld_memwb", MEM_WB, {1'b1, 5'd5, 32'hCAFEF00D});

        // Store with immediate ack.
        EX_MEM = mk(32'h204, 32'h12345678, 5'd0, 0, 1, 0, 2'b00, 0, 0, 0);
        #1;
        chk("st_idle_stall", MemStall, 1);
        tick();
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h204);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("st_done_req", dmem_req, 0);
        chk("st_done_we", dmem_we, 0);
        chk("st_done_stall", MemStall, 0);
        tick();
        EX_MEM = '0;
        chk("st_memwb_rw", MEM_WB[37], 0);
        #1;
        chk("st_after_req", dmem_req, 0);

        // Misaligned load: straight to DONE.
        EX_MEM = mk(32'h102, 0, 5'd4, 1, 0, 1, 2'b01, 0, 0, 0);
        #1;
        chk("mis_idle_stall", MemStall, 1);
        chk("mis_idle_req", dmem_req, 0);
        tick();
        chk("mis_done_req", dmem_req, 0);
        chk("mis_done_stall", MemStall, 0);
        chk("mis_buserr", bus_err, 1);
        tick();
        EX_MEM = '0;
        chk("mis_memwb", MEM_WB, {1'b1, 5'd4, 32'h0});

        // Reset in the middle of REQ.
        EX_MEM = mk(32'h400, 0, 5'd6, 1, 0, 1, 2'b01, 0, 0, 0);
        tick();
        chk("rq_req", dmem_req, 1);
        reset_b = 1'b0;
        #1;
        chk("rq_rst_req", dmem_req, 0);
        chk("rq_rst_addr", dmem_addr, 0);
        chk("rq_rst_buserr", bus_err, 0);
        EX_MEM = '0;
        @(negedge clk);
        reset_b = 1'b1;
        tick();
        tick();
        chk("rq_post_req", dmem_req, 0);
        chk("rq_post_stall", MemStall, 0);
        chk("rq_post_memwb", MEM_WB, 0);
        chk("rq_post_we", dmem_we, 0);

        // Load that never gets an ack.
        EX_MEM = mk(32'h300, 0, 5'd9, 1, 0, 1, 2'b01, 0, 0, 0);
        tick();
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_req_cycles", n, 16);
        chk("to_buserr", bus_err, 1);
        chk("to_done_stall", MemStall, 0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        EX_MEM = '0;
        chk("to_memwb", MEM_WB, {1'b1, 5'd9, 32'h0});
        #1;
        chk("to_late_req", dmem_req, 0);
        chk("to_late_stall", MemStall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("to_late_memwb", MEM_WB, 0);
        chk("to_late_req2", dmem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles in REQ awaiting dmem_ack.
REQ-002 SHALL have one clock and an asynchronous, active-low reset. Clock and reset ports are clk and reset_b, listed first.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_b  in  1  asynchronous active-low reset.
REQ-005 EX_MEM  in  139  pipeline bundle: [31:0] store data, [63:32] ALU result/address, [68:64] WriteReg, [69] MemRead, [70] MemWrite, [71] RegWrite, [73:72] MemToReg, [105:74] PC_Plus4, [137:106] LUData, [138] LUOp.
REQ-006 dmem_ack  in  1  memory completion strobe.
REQ-007 dmem_rdata  in  32  read data, valid with dmem_ack.
REQ-008 dmem_req, dmem_we  out  1 each  request and write-enable.
REQ-009 dmem_addr, dmem_wdata  out  32 each  registered address and store data.
REQ-010 MemStall  out  1  freezes EX_MEM and all earlier stages.
REQ-011 EX_MEM_Rd (5), EX_MEM_RdData (32), EX_MEM_RegWrite (1)  out  forwarding taps from the EX_MEM bundle.
REQ-012 MEM_WB  out  38  [31:0] RegWriteData, [36:32] WriteReg, [37] RegWrite.
REQ-013 bus_err  out  1  sticky error flag.

Function
REQ-014 SHALL implement an FSM with states IDLE, REQ and DONE.
REQ-015 IDLE, with MemRead|MemWrite=0: MemStall=0; MEM_WB loads the result every cycle.
REQ-016 IDLE, with MemRead|MemWrite=1 and address[1:0]=0: MemStall=1; dmem_addr, dmem_wdata and dmem_we=MemWrite are registered; go to REQ.
REQ-017 REQ: dmem_req=1; addr, wdata and we are held stable; MemStall=1; on dmem_ack, capture dmem_rdata and go to DONE.
REQ-018 DONE: dmem_req=0; MemStall=0; MEM_WB loads the result; go to IDLE. A memory op therefore takes at least 3 cycles.
REQ-019 Misaligned access (address[1:0]!=0) SHALL issue no request, set bus_err, and go directly to DONE with captured read data 32'h0.
REQ-020 Timeout: TIMEOUT cycles in REQ without ack SHALL set bus_err, force captured data to 32'h0, and go to DONE.
REQ-021 The timeout counter SHALL clear on entry to REQ. A late ack after timeout SHALL be ignored.
REQ-022 Write data select: LUOp=1 gives LUData; otherwise MemToReg 00 gives ALU result, 01 gives captured read data, 10 gives PC_Plus4, 11 gives ALU result.
REQ-023 MEM_WB.RegWrite SHALL be 0 (bubble) in every cycle where MemStall=1.
REQ-024 Forwarding taps SHALL be combinational from EX_MEM: Rd=[68:64], RegWrite=[71], RdData = LUData if LUOp, else PC_Plus4 if MemToReg=10, else ALU result.
REQ-025 A store (MemWrite) SHALL NOT assert dmem_req more than once per EX_MEM instruction.

Reset
REQ-026 reset_b low SHALL immediately force: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, MEM_WB=0, bus_err=0, counter=0.
REQ-027 Reset asserted mid-REQ SHALL abandon the access, with no completion, after reset releases.
REQ-028 MemStall SHALL be 0 from reset until the first memory op.

Structure
REQ-029 The EX_MEM and MEM_WB field bit positions, MemToReg encodings and FSM state encodings SHALL live in a shared pipeline package, so EX and WB use identical offsets.
REQ-030 Write-data selection SHALL be a single sub-module, wb_mux, reused by forwarding and MEM_WB.

Verification
REQ-031 ALU op: ALU=0x00000005, WriteReg=8, RegWrite=1, MemToReg=00 -> next edge MEM_WB = {1, 8, 0x00000005}; MemStall=0 throughout.
REQ-032 Load, ack on 2nd REQ cycle: addr=0x100, rdata=0xCAFEF00D, MemToReg=01 -> MemStall high for 3 cycles; one dmem_req burst; MEM_WB.RegWriteData=0xCAFEF00D.
REQ-033 Store, addr=0x204, wdata=0x12345678, immediate ack -> exactly one request cycle with dmem_we=1; MEM_WB.RegWrite=0.
REQ-034 Load with ack never given -> after 16 REQ cycles, bus_err=1, MEM_WB.RegWriteData=0, pipeline resumes; later ack is ignored.
REQ-035 Misaligned load, addr=0x102 -> no dmem_req; bus_err=1; completion in 2 cycles.
REQ-036 reset_b low during REQ -> dmem_req=0 immediately; after release, IDLE with all outputs at 0.
